// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory bus. Grants are registered, contention is
// round-robin, an owner is preempted after MAX_HOLD contested cycles, and every owner change passes through one idle TURN cycle.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_doe,
  input  logic [DATA_W-1:0] mem_din,
  output logic              proto_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] TURN = 2'd3;

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic owned, sel, own_req, other_req, own_rd, own_wr, clash;

  assign owned     = (state_q == OWN0) || (state_q == OWN1);
  assign sel       = (state_q == OWN1);
  assign own_req   = sel ? req1 : req0;
  assign other_req = sel ? req0 : req1;
  assign own_rd    = sel ? rd1 : rd0;
  assign own_wr    = sel ? wr1 : wr0;
  assign clash     = owned && own_rd && own_wr;

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign rdata     = mem_din;
  assign proto_err = proto_err_q;

  // Bus outputs follow the registered owner only, so a non-owner can never reach memory.
  always_comb begin
    mem_addr = '0;
    mem_dout = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    if (owned) begin
      mem_addr = sel ? addr1 : addr0;
      mem_dout = sel ? wdata1 : wdata0;
      mem_rd   = own_rd && !clash;
      mem_wr   = own_wr && !clash;
    end
    mem_doe = mem_wr;
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = '0;
    proto_err_d  = clash;
    case (state_q)
      IDLE: begin
        if (req0 && req1)
          state_d = last_owner_q ? OWN0 : OWN1;
        else if (req0)
          state_d = OWN0;
        else if (req1)
          state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (other_req)
          hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
        if (!own_req) begin
          last_owner_d = sel;
          hold_cnt_d   = '0;
          state_d      = other_req ? TURN : IDLE;
        end else if (other_req && hold_cnt_q == HOLD_LAST) begin
          last_owner_d = sel;
          hold_cnt_d   = '0;
          state_d      = TURN;
        end
      end
      default: begin
        // The waiting port is always the one that did not own the bus last.
        if (last_owner_q ? req0 : req1)
          state_d = last_owner_q ? OWN0 : OWN1;
        else if (last_owner_q ? req1 : req0)
          state_d = last_owner_q ? OWN1 : OWN0;
        else
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule
